cv32e40p_apu_arbiter: RTL and testbench
=======================================

CV32E40P_APU_ARBITER -- requirements
Module: cv32e40p_apu_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of cv32e40p APU requester ports (2..8).
REQ-002 SHALL have parameter MAX_OUTST, default 4, depth of the in-flight ID FIFO (power of 2, >=2).
REQ-003 SHALL have parameters APU_NARGS_CPU=3, APU_WOP_CPU=6, APU_NDSFLAGS_CPU=15 and APU_NUSFLAGS_CPU=5, with meanings as in cv32e40p_apu_core_pkg.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk_i is the clock and rst_ni is the asynchronous active-low reset.
REQ-005 clk_i  in  1  block clock.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 core_apu_req_i  in  NUM_CORES  per-core request.
REQ-008 core_apu_gnt_o  out  NUM_CORES  per-core grant.
REQ-009 core_apu_operands_i  in  NUM_CORES x APU_NARGS_CPU x 32  per-core operands.
REQ-010 core_apu_op_i  in  NUM_CORES x APU_WOP_CPU  per-core opcode.
REQ-011 core_apu_flags_i  in  NUM_CORES x APU_NDSFLAGS_CPU  per-core request flags.
REQ-012 core_apu_rvalid_o  out  NUM_CORES  per-core response valid.
REQ-013 core_apu_result_o  out  32  shared result, broadcast to all cores.
REQ-014 core_apu_flags_o  out  APU_NUSFLAGS_CPU  shared response flags, broadcast to all cores.
REQ-015 apu_req_o, apu_gnt_i, apu_operands_o, apu_op_o, apu_flags_o (out/in/out/out/out) SHALL form the shared APU request channel, with widths as the per-core request signals.
REQ-016 apu_rvalid_i, apu_result_i, apu_flags_i (in) SHALL form the shared APU response channel.
REQ-017 outstanding_o  out  $clog2(MAX_OUTST)+1  number of in-flight operations.
REQ-018 resp_err_o  out  1  sticky flag: response received with no operation in flight.

Function
REQ-019 Arbitration SHALL be round-robin: the winner is the first requesting core at or after rr_ptr, searching in ascending index order with wrap-around.
REQ-020 When the FIFO is not full and any core is requesting, apu_req_o SHALL be 1 and apu_operands_o/op_o/flags_o SHALL equal the winner's inputs; otherwise apu_req_o SHALL be 0 and these outputs SHALL be 0.
REQ-021 core_apu_gnt_o[i] SHALL equal apu_gnt_i & apu_req_o & (winner==i), combinationally, with zero added latency.
REQ-022 On a handshake (apu_req_o & apu_gnt_i): the winner ID SHALL be pushed to the FIFO and rr_ptr SHALL become (winner+1) mod NUM_CORES at the next clock edge.
REQ-023 rr_ptr SHALL hold when no handshake occurs, so the winner stays stable while a request waits for grant.
REQ-024 The APU returns responses in order; on apu_rvalid_i with a non-empty FIFO, core_apu_rvalid_o[head] SHALL be 1 in the same cycle and the head SHALL be popped at the clock edge.
REQ-025 core_apu_result_o and core_apu_flags_o SHALL be driven directly from apu_result_i and apu_flags_i.
REQ-026 Full FIFO (count==MAX_OUTST): apu_req_o SHALL be 0, even if apu_rvalid_i is high in the same cycle; this removes the rvalid-to-gnt combinational path.
REQ-027 Simultaneous push and pop when not full: count SHALL be unchanged and both pointers SHALL advance.
REQ-028 apu_rvalid_i with an empty FIFO: no core_apu_rvalid_o SHALL assert, the response SHALL be dropped, and resp_err_o SHALL be set until reset.
REQ-029 FIFO pointers SHALL wrap modulo MAX_OUTST.
REQ-030 outstanding_o SHALL equal the FIFO count, registered.

Reset
REQ-031 While rst_ni=0: rr_ptr=0, FIFO empty, outstanding_o=0, resp_err_o=0, and all core_apu_rvalid_o=0.
REQ-032 A reset asserted mid-operation SHALL discard all in-flight IDs; any response arriving afterwards SHALL follow REQ-028.

Verification
REQ-033 Cores 0 and 1 request continuously, apu_gnt_i=1, 1-cycle APU -> grants alternate 0,1,0,1; each rvalid routes to the matching core.
REQ-034 Only core 1 requests, apu_gnt_i low for 3 cycles -> apu_req_o=1 with core 1 operands held stable; core_apu_gnt_o[1] pulses on the 4th cycle.
REQ-035 MAX_OUTST=4, no responses, 5 grants attempted -> 4 handshakes, outstanding_o=4, apu_req_o=0; one rvalid -> next cycle apu_req_o=1.
REQ-036 apu_rvalid_i pulse after reset with no requests -> no core_apu_rvalid_o; resp_err_o=1 next cycle and stays 1.
REQ-037 Grant and rvalid in the same cycle with count=2 -> count stays 2; the response goes to the oldest ID.
REQ-038 rst_ni pulsed with 3 operations in flight -> outstanding_o=0, rr_ptr=0; the next request from core 0 wins.

Source files
------------

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU between NUM_CORES cv32e40p cores; responses routed in order via an ID FIFO.
// Latency: request/grant and response routing are combinational; rr_ptr, FIFO and counters update at the clock edge.
// Backpressure: apu_req_o is held low while MAX_OUTST operations are in flight; a waiting winner is held until apu_gnt_i.
module cv32e40p_apu_arbiter #(
    parameter int NUM_CORES        = 2,
    parameter int MAX_OUTST        = 4,
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic [NUM_CORES-1:0]                             core_apu_req_i,
    output logic [NUM_CORES-1:0]                             core_apu_gnt_o,
    input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0]    core_apu_operands_i,
    input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]            core_apu_op_i,
    input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]       core_apu_flags_i,
    output logic [NUM_CORES-1:0]                             core_apu_rvalid_o,
    output logic [31:0]                                      core_apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                      core_apu_flags_o,
    output logic                                             apu_req_o,
    input  logic                                             apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                   apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                           apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                      apu_flags_o,
    input  logic                                             apu_rvalid_i,
    input  logic [31:0]                                      apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                      apu_flags_i,
    output logic [$clog2(MAX_OUTST):0]                       outstanding_o,
    output logic                                             resp_err_o
);

    localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PW  = $clog2(MAX_OUTST);
    localparam int CW  = PW + 1;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic           any_req;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [IDW-1:0] id_mem [MAX_OUTST];
    logic [IDW-1:0] head_id;

    // First requester at or after rr_ptr, ascending with wrap-around.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        any_req = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CORES;
            if (!any_req && core_apu_req_i[idx]) begin
                any_req = 1'b1;
                winner  = IDW'(idx);
            end
        end
    end

    assign full    = (count == CW'(MAX_OUTST));
    assign empty   = (count == '0);
    assign head_id = id_mem[rd_ptr];

    // Full blocks requests regardless of a same-cycle response, keeping rvalid off the grant path.
    assign apu_req_o = any_req & ~full;
    assign push      = apu_req_o & apu_gnt_i;
    assign pop       = apu_rvalid_i & ~empty;

    assign apu_operands_o = apu_req_o ? core_apu_operands_i[winner] : '0;
    assign apu_op_o       = apu_req_o ? core_apu_op_i[winner]       : '0;
    assign apu_flags_o    = apu_req_o ? core_apu_flags_i[winner]    : '0;

    always_comb begin
        core_apu_gnt_o    = '0;
        core_apu_rvalid_o = '0;
        if (push) core_apu_gnt_o[winner]     = 1'b1;
        if (pop)  core_apu_rvalid_o[head_id] = 1'b1;
    end

    assign core_apu_result_o = apu_result_i;
    assign core_apu_flags_o  = apu_flags_i;
    assign outstanding_o     = count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            resp_err_o <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr <= (winner == IDW'(NUM_CORES - 1)) ? '0 : winner + IDW'(1);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (apu_rvalid_i && empty) resp_err_o <= 1'b1;
        end
    end

    // ID storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push) id_mem[wr_ptr] <= winner;
    end

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for cv32e40p_apu_arbiter (2 cores, 4-deep ID FIFO) with hand-computed expectations.
module tb_cv32e40p_apu_arbiter;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [1:0]            core_apu_req_i;
    logic [1:0]            core_apu_gnt_o;
    logic [1:0][2:0][31:0] core_apu_operands_i;
    logic [1:0][5:0]       core_apu_op_i;
    logic [1:0][14:0]      core_apu_flags_i;
    logic [1:0]            core_apu_rvalid_o;
    logic [31:0]           core_apu_result_o;
    logic [4:0]            core_apu_flags_o;
    logic                  apu_req_o;
    logic                  apu_gnt_i;
    logic [2:0][31:0]      apu_operands_o;
    logic [5:0]            apu_op_o;
    logic [14:0]           apu_flags_o;
    logic                  apu_rvalid_i;
    logic [31:0]           apu_result_i;
    logic [4:0]            apu_flags_i;
    logic [2:0]            outstanding_o;
    logic                  resp_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    cv32e40p_apu_arbiter dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .core_apu_req_i      (core_apu_req_i),
        .core_apu_gnt_o      (core_apu_gnt_o),
        .core_apu_operands_i (core_apu_operands_i),
        .core_apu_op_i       (core_apu_op_i),
        .core_apu_flags_i    (core_apu_flags_i),
        .core_apu_rvalid_o   (core_apu_rvalid_o),
        .core_apu_result_o   (core_apu_result_o),
        .core_apu_flags_o    (core_apu_flags_o),
        .apu_req_o           (apu_req_o),
        .apu_gnt_i           (apu_gnt_i),
        .apu_operands_o      (apu_operands_o),
        .apu_op_o            (apu_op_o),
        .apu_flags_o         (apu_flags_o),
        .apu_rvalid_i        (apu_rvalid_i),
        .apu_result_i        (apu_result_i),
        .apu_flags_i         (apu_flags_i),
        .outstanding_o       (outstanding_o),
        .resp_err_o          (resp_err_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1ns later, well clear of the rising edge.
    task automatic step(input logic [1:0] req, input logic gnt, input logic rv);
        @(negedge clk_i);
        core_apu_req_i = req;
        apu_gnt_i      = gnt;
        apu_rvalid_i   = rv;
        #1;
    endtask

    initial begin
        rst_ni              = 1'b0;
        core_apu_req_i      = '0;
        apu_gnt_i           = 1'b0;
        apu_rvalid_i        = 1'b0;
        apu_result_i        = 32'h0;
        apu_flags_i         = 5'h0;
        core_apu_operands_i[0] = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
        core_apu_operands_i[1] = {32'h1000_001C, 32'h1000_001B, 32'h1000_001A};
        core_apu_op_i[0]    = 6'h05;
        core_apu_op_i[1]    = 6'h2A;
        core_apu_flags_i[0] = 15'h1111;
        core_apu_flags_i[1] = 15'h2222;

        // Reset state
        step(2'b00, 1'b0, 1'b1);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_resp_err", resp_err_o, 0);
        check("rst_rvalid", core_apu_rvalid_o, 0);
        check("rst_req", apu_req_o, 0);
        step(2'b00, 1'b0, 1'b0);
        rst_ni = 1'b1;

        // Stray response with nothing in flight
        apu_result_i = 32'hDEAD_BEEF;
        apu_flags_i  = 5'h15;
        step(2'b00, 1'b0, 1'b1);
        check("stray_rvalid", core_apu_rvalid_o, 0);
        check("stray_err_before", resp_err_o, 0);
        check("result_bcast", core_apu_result_o, 32'hDEAD_BEEF);
        check("flags_bcast", core_apu_flags_o, 5'h15);
        check("idle_operands", apu_operands_o, 0);
        step(2'b00, 1'b0, 1'b0);
        check("stray_err_set", resp_err_o, 1);
        step(2'b00, 1'b0, 1'b0);
        check("stray_err_sticky", resp_err_o, 1);

        // Two cores contend, single-cycle APU: grants alternate, responses route back
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 1'b1, (k != 0));
            check($sformatf("rr_gnt%0d", k), core_apu_gnt_o, 2'b01 << (k % 2));
            check($sformatf("rr_ops%0d", k), apu_operands_o, core_apu_operands_i[k % 2]);
            check($sformatf("rr_op%0d", k), apu_op_o, core_apu_op_i[k % 2]);
            check($sformatf("rr_rvalid%0d", k), core_apu_rvalid_o, (k == 0) ? 2'b00 : (2'b01 << ((k - 1) % 2)));
            check($sformatf("rr_outst%0d", k), outstanding_o, (k == 0) ? 0 : 1);
        end
        step(2'b00, 1'b0, 1'b1);
        check("rr_last_rvalid", core_apu_rvalid_o, 2'b10);
        step(2'b00, 1'b0, 1'b0);
        check("rr_drained", outstanding_o, 0);

        // Lone requester waits three cycles for the grant
        for (int k = 0; k < 3; k++) begin
            step(2'b10, 1'b0, 1'b0);
            check($sformatf("wait_req%0d", k), apu_req_o, 1);
            check($sformatf("wait_ops%0d", k), apu_operands_o, core_apu_operands_i[1]);
            check($sformatf("wait_flags%0d", k), apu_flags_o, 15'h2222);
            check($sformatf("wait_gnt%0d", k), core_apu_gnt_o, 2'b00);
        end
        step(2'b10, 1'b1, 1'b0);
        check("wait_gnt_pulse", core_apu_gnt_o, 2'b10);
        step(2'b00, 1'b0, 1'b1);
        check("wait_outst", outstanding_o, 1);
        check("wait_rvalid", core_apu_rvalid_o, 2'b10);

        // Fill the FIFO: five attempts, four handshakes
        for (int k = 0; k < 5; k++) begin
            step(2'b01, 1'b1, 1'b0);
            check($sformatf("fill_gnt%0d", k), core_apu_gnt_o, (k < 4) ? 2'b01 : 2'b00);
            check($sformatf("fill_req%0d", k), apu_req_o, (k < 4));
        end
        check("full_outst", outstanding_o, 4);
        check("full_ops_zero", apu_operands_o, 0);
        step(2'b01, 1'b1, 1'b1);
        check("full_rv_req", apu_req_o, 0);
        check("full_rv_gnt", core_apu_gnt_o, 2'b00);
        check("full_rv_rvalid", core_apu_rvalid_o, 2'b01);
        step(2'b01, 1'b0, 1'b0);
        check("unfull_req", apu_req_o, 1);
        check("unfull_outst", outstanding_o, 3);
        step(2'b00, 1'b0, 1'b1);
        check("drain_rvalid", core_apu_rvalid_o, 2'b01);

        // Grant and response together at count 2; pointers have wrapped by now
        step(2'b10, 1'b1, 1'b1);
        check("both_pre_outst", outstanding_o, 2);
        check("both_gnt", core_apu_gnt_o, 2'b10);
        check("both_rvalid_oldest", core_apu_rvalid_o, 2'b01);
        step(2'b00, 1'b0, 1'b1);
        check("both_post_outst", outstanding_o, 2);
        check("order_rv0", core_apu_rvalid_o, 2'b01);
        step(2'b00, 1'b0, 1'b1);
        check("order_rv1", core_apu_rvalid_o, 2'b10);
        step(2'b00, 1'b0, 1'b0);
        check("order_empty", outstanding_o, 0);

        // Reset with three in flight and rr_ptr on core 1
        for (int k = 0; k < 3; k++) step(2'b01, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        check("pre_rst_outst", outstanding_o, 3);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_outst", outstanding_o, 0);
        check("mid_rst_err", resp_err_o, 0);
        step(2'b00, 1'b0, 1'b0);
        rst_ni = 1'b1;
        step(2'b11, 1'b0, 1'b1);
        check("post_rst_rvalid", core_apu_rvalid_o, 2'b00);
        check("post_rst_ops", apu_operands_o, core_apu_operands_i[0]);
        step(2'b11, 1'b1, 1'b0);
        check("post_rst_err", resp_err_o, 1);
        check("post_rst_gnt", core_apu_gnt_o, 2'b01);
        step(2'b00, 1'b0, 1'b0);
        check("post_rst_outst", outstanding_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
